// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and helpers for the reg_file slice
// Purpose: default N/DEPTH/AW values and a clog2 helper for deriving AW.
// Ports: none (package).
package reg_file_pkg;

   // Smallest a such that 2^a >= v (minimum 1 so a 1-entry space still has an address bit).
   function automatic int clog2(input int v);
      int a;
      a = 1;
      while ((1 << a) < v) a++;
      return a;
   endfunction

   localparam int N_DEF     = 12;
   localparam int DEPTH_DEF = 8;
   localparam int AW_DEF    = clog2(DEPTH_DEF);

endpackage

// File: rtl/reg_file_rdport.sv
// rtl/reg_file_rdport.sv - one registered read port with range check and write bypass
// Purpose: selects an entry from the flattened storage, forwards same-edge write data,
//          and registers the result.
// Ports:
//   Clk, Rst_n           clock, async active-low reset
//   Clr                  synchronous clear (forces a zero/invalid read result)
//   We, Waddr, Wdata     write port of the parent, used for bypass
//   Re, Raddr            read enable and address
//   entries, valid       flattened storage and per-entry valid bits
//   Rdata, Rvalid        registered read result
module reg_file_rdport
   import reg_file_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               Clr,
   input  logic               We,
   input  logic [AW-1:0]      Waddr,
   input  logic [N-1:0]       Wdata,
   input  logic               Re,
   input  logic [AW-1:0]      Raddr,
   input  logic [N*DEPTH-1:0] entries,
   input  logic [DEPTH-1:0]   valid,
   output logic [N-1:0]       Rdata,
   output logic               Rvalid
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic         in_range;
   logic         bypass;
   logic [N-1:0] sel_data;
   logic         sel_valid;

   assign in_range = ({1'b0, Raddr} < DEPTH_W);
   // An in-range Raddr matching Waddr implies the write is in range too.
   assign bypass   = We && (Waddr == Raddr) && in_range;

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (Raddr == AW'(k)) begin
            sel_data  = entries[k*N +: N];
            sel_valid = valid[k];
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Rdata  <= '0;
         Rvalid <= 1'b0;
      end else if (Re) begin
         if (Clr || !in_range) begin
            Rdata  <= '0;
            Rvalid <= 1'b0;
         end else if (bypass) begin
            Rdata  <= Wdata;
            Rvalid <= 1'b1;
         end else begin
            Rdata  <= sel_data;
            Rvalid <= sel_valid;
         end
      end
   end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - DEPTH x N register file, one write port, two registered read ports
// Purpose: addressable operand storage with per-entry valid tracking and write-to-read bypass.
// Ports:
//   Clk, Rst_n                        clock, async active-low reset
//   Clr                               synchronous clear of all entries and valid bits
//   We, Waddr, Wdata                  write port (out-of-range writes are dropped)
//   Re0, Raddr0, Rdata0, Rvalid0      read port 0
//   Re1, Raddr1, Rdata1, Rvalid1      read port 1
//   ValidMask                         per-entry valid bits, bit k = entry k
module reg_file
   import reg_file_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Clr,
   input  logic             We,
   input  logic [AW-1:0]    Waddr,
   input  logic [N-1:0]     Wdata,
   input  logic             Re0,
   input  logic [AW-1:0]    Raddr0,
   output logic [N-1:0]     Rdata0,
   output logic             Rvalid0,
   input  logic             Re1,
   input  logic [AW-1:0]    Raddr1,
   output logic [N-1:0]     Rdata1,
   output logic             Rvalid1,
   output logic [DEPTH-1:0] ValidMask
);

   logic [N*DEPTH-1:0] entries;

   for (genvar k = 0; k < DEPTH; k++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(k);
      logic [N-1:0] data_q;
      logic         valid_q;

      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (Clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (We && (Waddr == IDX)) begin
            // Addresses >= DEPTH match no entry, so such writes fall through untouched.
            data_q  <= Wdata;
            valid_q <= 1'b1;
         end
      end

      assign entries[k*N +: N] = data_q;
      assign ValidMask[k]      = valid_q;
   end

   reg_file_rdport #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_rd0 (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Clr     (Clr),
      .We      (We),
      .Waddr   (Waddr),
      .Wdata   (Wdata),
      .Re      (Re0),
      .Raddr   (Raddr0),
      .entries (entries),
      .valid   (ValidMask),
      .Rdata   (Rdata0),
      .Rvalid  (Rvalid0)
   );

   reg_file_rdport #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_rd1 (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Clr     (Clr),
      .We      (We),
      .Waddr   (Waddr),
      .Wdata   (Wdata),
      .Re      (Re1),
      .Raddr   (Raddr1),
      .entries (entries),
      .valid   (ValidMask),
      .Rdata   (Rdata1),
      .Rvalid  (Rvalid1)
   );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (DEPTH=8 and DEPTH=6 instances)
module tb_reg_file;

   logic        Clk;
   logic        Rst_n;
   logic        Clr;
   logic        We;
   logic [2:0]  Waddr;
   logic [11:0] Wdata;
   logic        Re0;
   logic [2:0]  Raddr0;
   logic        Re1;
   logic [2:0]  Raddr1;

   logic [11:0] a_rd0, a_rd1, b_rd0, b_rd1;
   logic        a_rv0, a_rv1, b_rv0, b_rv1;
   logic [7:0]  a_vm;
   logic [5:0]  b_vm;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   reg_file #(.N(12), .DEPTH(8), .AW(3)) dut_a (
      .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
      .Re0(Re0), .Raddr0(Raddr0), .Rdata0(a_rd0), .Rvalid0(a_rv0),
      .Re1(Re1), .Raddr1(Raddr1), .Rdata1(a_rd1), .Rvalid1(a_rv1),
      .ValidMask(a_vm)
   );

   reg_file #(.N(12), .DEPTH(6), .AW(3)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .We(We), .Waddr(Waddr), .Wdata(Wdata),
      .Re0(Re0), .Raddr0(Raddr0), .Rdata0(b_rd0), .Rvalid0(b_rv0),
      .Re1(Re1), .Raddr1(Raddr1), .Rdata1(b_rd1), .Rvalid1(b_rv1),
      .ValidMask(b_vm)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
   logic [11:0] m_mem [2][8];
   logic        m_val [2][8];
   logic [11:0] m_rd  [2][2];
   logic        m_rv  [2][2];

   function automatic int depth_of(input int c);
      return (c == 0) ? 8 : 6;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 8; k++) begin
            m_mem[c][k] = '0;
            m_val[c][k] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            m_rd[c][p] = '0;
            m_rv[c][p] = 1'b0;
         end
      end
   endtask

   // One clock edge of the register file, straight from the behavioural rules.
   task automatic model_step();
      if (!Rst_n) return;
      for (int c = 0; c < 2; c++) begin
         int d;
         d = depth_of(c);
         for (int p = 0; p < 2; p++) begin
            logic       re;
            logic [2:0] ra;
            re = (p == 0) ? Re0 : Re1;
            ra = (p == 0) ? Raddr0 : Raddr1;
            if (re) begin
               if (Clr || int'(ra) >= d) begin
                  m_rd[c][p] = '0;
                  m_rv[c][p] = 1'b0;
               end else if (We && Waddr == ra) begin
                  m_rd[c][p] = Wdata;
                  m_rv[c][p] = 1'b1;
               end else begin
                  m_rd[c][p] = m_mem[c][ra];
                  m_rv[c][p] = m_val[c][ra];
               end
            end
         end
         if (Clr) begin
            for (int k = 0; k < 8; k++) begin
               m_mem[c][k] = '0;
               m_val[c][k] = 1'b0;
            end
         end else if (We && int'(Waddr) < d) begin
            m_mem[c][Waddr] = Wdata;
            m_val[c][Waddr] = 1'b1;
         end
      end
   endtask

   function automatic logic [7:0] model_mask(input int c);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < depth_of(c); k++) m[k] = m_val[c][k];
      return m;
   endfunction

   always @(negedge Clk) begin
      if (cmp_en) begin
         check("a_rdata0",  {20'd0, a_rd0}, {20'd0, m_rd[0][0]});
         check("a_rvalid0", {31'd0, a_rv0}, {31'd0, m_rv[0][0]});
         check("a_rdata1",  {20'd0, a_rd1}, {20'd0, m_rd[0][1]});
         check("a_rvalid1", {31'd0, a_rv1}, {31'd0, m_rv[0][1]});
         check("a_mask",    {24'd0, a_vm},  {24'd0, model_mask(0)});
         check("b_rdata0",  {20'd0, b_rd0}, {20'd0, m_rd[1][0]});
         check("b_rvalid0", {31'd0, b_rv0}, {31'd0, m_rv[1][0]});
         check("b_rdata1",  {20'd0, b_rd1}, {20'd0, m_rd[1][1]});
         check("b_rvalid1", {31'd0, b_rv1}, {31'd0, m_rv[1][1]});
         check("b_mask",    {24'd0, b_vm},  {26'd0, model_mask(1)});
      end
   end

   task automatic idle();
      Clr = 0; We = 0; Waddr = '0; Wdata = '0;
      Re0 = 0; Raddr0 = '0; Re1 = 0; Raddr1 = '0;
   endtask

   task automatic cyc();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   initial begin
      Rst_n = 1'b0;
      idle();
      model_reset();
      cmp_en = 1;
      cyc();
      cyc();
      Rst_n = 1'b1;

      // Dirty the outputs so the asynchronous reset has something to clear.
      We = 1; Waddr = 3'd1; Wdata = 12'h5A5; Re0 = 1; Raddr0 = 3'd1;
      cyc(); idle();
      check("pre_rst_rdata0", {20'd0, a_rd0}, 32'h5A5);

      // Mid-cycle reset: outputs clear with no clock edge.
      cyc();
      #2;
      Rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_rdata0",  {20'd0, a_rd0}, 32'h0);
      check("rst_rvalid0", {31'd0, a_rv0}, 32'h0);
      check("rst_mask_a",  {24'd0, a_vm},  32'h0);
      check("rst_mask_b",  {26'd0, b_vm},  32'h0);
      #3;
      Rst_n = 1'b1;

      // Empty read after reset.
      Re0 = 1; Raddr0 = 3'd3;
      cyc(); idle();
      check("empty_rdata0",  {20'd0, a_rd0}, 32'h0);
      check("empty_rvalid0", {31'd0, a_rv0}, 32'h0);
      check("empty_mask",    {24'd0, a_vm},  32'h00);

      // Write then read.
      We = 1; Waddr = 3'd5; Wdata = 12'hABC;
      cyc(); idle();
      Re0 = 1; Raddr0 = 3'd5;
      cyc(); idle();
      check("wr_rd_rdata0",  {20'd0, a_rd0}, 32'hABC);
      check("wr_rd_rvalid0", {31'd0, a_rv0}, 32'h1);
      check("wr_rd_mask",    {24'd0, a_vm},  32'h20);

      // Bypass over a stale value.
      We = 1; Waddr = 3'd2; Wdata = 12'h777;
      cyc(); idle();
      We = 1; Waddr = 3'd2; Wdata = 12'h123; Re1 = 1; Raddr1 = 3'd2;
      cyc(); idle();
      check("bypass_rdata1",  {20'd0, a_rd1}, 32'h123);
      check("bypass_rvalid1", {31'd0, a_rv1}, 32'h1);

      // Hold with Re0=0, then dual read of the same address.
      We = 1; Waddr = 3'd5; Wdata = 12'h001;
      cyc(); idle();
      check("hold_rdata0", {20'd0, a_rd0}, 32'hABC);
      Re0 = 1; Raddr0 = 3'd5; Re1 = 1; Raddr1 = 3'd5;
      cyc(); idle();
      check("dual_rdata0", {20'd0, a_rd0}, 32'h001);
      check("dual_rdata1", {20'd0, a_rd1}, 32'h001);

      // Out of range on the DEPTH=6 instance; in range on the DEPTH=8 one.
      We = 1; Waddr = 3'd7; Wdata = 12'hFFF;
      cyc(); idle();
      check("oor_wr_mask_b", {26'd0, b_vm}, 32'h24);
      check("oor_wr_mask_a", {24'd0, a_vm}, 32'hA4);
      Re0 = 1; Raddr0 = 3'd6; Re1 = 1; Raddr1 = 3'd7;
      cyc(); idle();
      check("oor_rd_rdata0_b",  {20'd0, b_rd0}, 32'h0);
      check("oor_rd_rvalid0_b", {31'd0, b_rv0}, 32'h0);
      check("oor_rd_rdata1_b",  {20'd0, b_rd1}, 32'h0);
      check("oor_rd_rdata1_a",  {20'd0, a_rd1}, 32'hFFF);

      // Clear beats write.
      We = 1; Waddr = 3'd0; Wdata = 12'h010;
      cyc();
      Waddr = 3'd1; Wdata = 12'h011;
      cyc(); idle();
      Clr = 1; We = 1; Waddr = 3'd4; Wdata = 12'h444; Re0 = 1; Raddr0 = 3'd0;
      cyc(); idle();
      check("clr_mask",    {24'd0, a_vm},  32'h0);
      check("clr_rdata0",  {20'd0, a_rd0}, 32'h0);
      check("clr_rvalid0", {31'd0, a_rv0}, 32'h0);
      Re0 = 1; Raddr0 = 3'd4;
      cyc(); idle();
      check("clr_no_wr_rvalid0", {31'd0, a_rv0}, 32'h0);
      check("clr_no_wr_rdata0",  {20'd0, a_rd0}, 32'h0);

      cyc();
      #5;
      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
